// File: rtl/huff_decoder.sv
// Serial Huffman decoder: loads a {char, mask/value} table over the 12-bit pin bus,
// then turns one code bit per cycle back into 8-bit characters.
module huff_decoder #(
    parameter int MAX_CHAR_COUNT = 3,
    parameter int BIT_WIDTH      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] io_in,
    output logic [11:0] io_out
);

    localparam int NWORDS = 2 * MAX_CHAR_COUNT;
    localparam int CW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int LW     = $clog2(BIT_WIDTH + 1);

    typedef enum logic {
        LOAD,
        DECODE
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]        wordCnt_q, wordCnt_d;
    logic [BIT_WIDTH-1:0] accBits_q, accBits_d;
    logic [LW-1:0]        accLen_q, accLen_d;

    logic [7:0]           charTab_q [MAX_CHAR_COUNT];
    logic [7:0]           charTab_d [MAX_CHAR_COUNT];
    logic [BIT_WIDTH-1:0] mask_q    [MAX_CHAR_COUNT];
    logic [BIT_WIDTH-1:0] mask_d    [MAX_CHAR_COUNT];
    logic [BIT_WIDTH-1:0] value_q   [MAX_CHAR_COUNT];
    logic [BIT_WIDTH-1:0] value_d   [MAX_CHAR_COUNT];

    logic       tableReady_q, tableReady_d;
    logic       err_q, err_d;
    logic       charValid_q, charValid_d;
    logic [7:0] char_q, char_d;

    logic       inValid;
    logic [1:0] cmd;
    logic [7:0] payload;
    logic       bitIn;
    logic       unusedBits;

    assign inValid    = io_in[11];
    assign cmd        = io_in[10:9];
    assign payload    = io_in[7:0];
    assign bitIn      = io_in[0];
    assign unusedBits = io_in[8];

    logic [BIT_WIDTH-1:0] nb;
    logic [LW-1:0]        nl;
    logic [BIT_WIDTH-1:0] thermo;
    logic                 hit;
    logic [7:0]           hitChar;

    // Candidate code after this bit; an entry matches only when its mask is exactly
    // the thermometer of the new length, so disabled masks can never match.
    always_comb begin
        nb = (accBits_q << 1) | BIT_WIDTH'(bitIn);
        nl = accLen_q + LW'(1);
        thermo = '0;
        for (int i = 0; i < BIT_WIDTH; i++) begin
            thermo[i] = (LW'(i) < nl);
        end
        hit     = 1'b0;
        hitChar = 8'h00;
        for (int k = MAX_CHAR_COUNT - 1; k >= 0; k--) begin
            if ((mask_q[k] == thermo) && ((value_q[k] & mask_q[k]) == (nb & mask_q[k]))) begin
                hit     = 1'b1;
                hitChar = charTab_q[k];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        wordCnt_d    = wordCnt_q;
        accBits_d    = accBits_q;
        accLen_d     = accLen_q;
        charTab_d    = charTab_q;
        mask_d       = mask_q;
        value_d      = value_q;
        tableReady_d = tableReady_q;
        err_d        = 1'b0;
        charValid_d  = 1'b0;
        char_d       = char_q;

        if (inValid) begin
            if (cmd == 2'b10) begin
                state_d      = LOAD;
                wordCnt_d    = '0;
                accBits_d    = '0;
                accLen_d     = '0;
                tableReady_d = 1'b0;
                for (int k = 0; k < MAX_CHAR_COUNT; k++) begin
                    mask_d[k] = '0;
                end
            end else if ((state_q == LOAD) && (cmd == 2'b00)) begin
                for (int k = 0; k < MAX_CHAR_COUNT; k++) begin
                    if (wordCnt_q == CW'(2 * k)) begin
                        charTab_d[k] = payload;
                    end
                    if (wordCnt_q == CW'(2 * k + 1)) begin
                        mask_d[k]  = payload[2*BIT_WIDTH-1:BIT_WIDTH];
                        value_d[k] = payload[BIT_WIDTH-1:0];
                    end
                end
                if (wordCnt_q == CW'(NWORDS - 1)) begin
                    state_d      = DECODE;
                    tableReady_d = 1'b1;
                    wordCnt_d    = '0;
                end else begin
                    wordCnt_d = wordCnt_q + CW'(1);
                end
            end else if ((state_q == DECODE) && (cmd == 2'b01)) begin
                if (hit) begin
                    char_d      = hitChar;
                    charValid_d = 1'b1;
                    accBits_d   = '0;
                    accLen_d    = '0;
                end else if (nl == LW'(BIT_WIDTH)) begin
                    err_d     = 1'b1;
                    accBits_d = '0;
                    accLen_d  = '0;
                end else begin
                    accBits_d = nb;
                    accLen_d  = nl;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= LOAD;
            wordCnt_q    <= '0;
            accBits_q    <= '0;
            accLen_q     <= '0;
            tableReady_q <= 1'b0;
            err_q        <= 1'b0;
            charValid_q  <= 1'b0;
            char_q       <= 8'h00;
            for (int k = 0; k < MAX_CHAR_COUNT; k++) begin
                charTab_q[k] <= 8'h00;
                mask_q[k]    <= '0;
                value_q[k]   <= '0;
            end
        end else begin
            state_q      <= state_d;
            wordCnt_q    <= wordCnt_d;
            accBits_q    <= accBits_d;
            accLen_q     <= accLen_d;
            tableReady_q <= tableReady_d;
            err_q        <= err_d;
            charValid_q  <= charValid_d;
            char_q       <= char_d;
            charTab_q    <= charTab_d;
            mask_q       <= mask_d;
            value_q      <= value_d;
        end
    end

    assign io_out = {1'b0, tableReady_q, err_q, charValid_q, char_q};

endmodule

// File: tb/tb_huff_decoder.sv
// Table-driven bench for huff_decoder: each stimulus word pushes its expected io_out
// onto a scoreboard queue that is popped one cycle later.
module tb_huff_decoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] io_in = 12'h000;
    logic [11:0] io_out;

    always #5 clk = ~clk;

    huff_decoder #(
        .MAX_CHAR_COUNT(3),
        .BIT_WIDTH(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .io_in(io_in),
        .io_out(io_out)
    );

    typedef struct {
        logic        rst;
        logic [11:0] stim;
        logic [11:0] expOut;
    } vec_t;

    vec_t        vecs[$];
    logic [11:0] expQ[$];
    string       nameQ[$];
    int          checks = 0;
    int          errors = 0;

    function automatic logic [11:0] tw(input logic [7:0] d);
        return {4'b1000, d};
    endfunction

    function automatic logic [11:0] bw(input logic b);
        return {4'b1010, 7'b0, b};
    endfunction

    function automatic logic [11:0] eo(input logic tr, input logic er, input logic cv, input logic [7:0] ch);
        return {1'b0, tr, er, cv, ch};
    endfunction

    localparam logic [11:0] FLUSH = 12'hC00;

    task automatic checkOutput();
        logic [11:0] e;
        string       n;
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard-empty actual=%h required=<entry>", io_out);
        end else begin
            e = expQ.pop_front();
            n = nameQ.pop_front();
            if (io_out !== e) begin
                errors++;
                $display("[TB] FAIL %s actual=%h required=%h", n, io_out, e);
            end
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [11:0] stim, input logic [11:0] expOut, input string name);
        @(negedge clk);
        reset = rst;
        io_in = stim;
        expQ.push_back(expOut);
        nameQ.push_back(name);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    function automatic void addVec(input logic rst, input logic [11:0] stim, input logic [11:0] expOut);
        vec_t v;
        v.rst    = rst;
        v.stim   = stim;
        v.expOut = expOut;
        vecs.push_back(v);
    endfunction

    initial begin
        // Reset, ignored commands in LOAD, basic table, basic decode
        addVec(1, 12'h000, eo(0, 0, 0, 8'h00));
        addVec(0, bw(1),   eo(0, 0, 0, 8'h00));
        addVec(0, 12'h061, eo(0, 0, 0, 8'h00));
        addVec(0, tw(8'h61), eo(0, 0, 0, 8'h00));
        addVec(0, tw(8'h04), eo(0, 0, 0, 8'h00));
        addVec(0, tw(8'h62), eo(0, 0, 0, 8'h00));
        addVec(0, tw(8'h0E), eo(0, 0, 0, 8'h00));
        addVec(0, tw(8'h63), eo(0, 0, 0, 8'h00));
        addVec(0, tw(8'h0F), eo(1, 0, 0, 8'h00));
        addVec(0, bw(0), eo(1, 0, 1, 8'h61));
        addVec(0, bw(1), eo(1, 0, 0, 8'h61));
        addVec(0, bw(0), eo(1, 0, 1, 8'h62));
        addVec(0, bw(1), eo(1, 0, 0, 8'h62));
        addVec(0, bw(1), eo(1, 0, 1, 8'h63));
        addVec(0, tw(8'h41), eo(1, 0, 0, 8'h63));
        addVec(0, 12'hE01, eo(1, 0, 0, 8'h63));
        addVec(0, bw(0), eo(1, 0, 1, 8'h61));
        addVec(0, 12'h201, eo(1, 0, 0, 8'h61));
        addVec(0, bw(0), eo(1, 0, 1, 8'h61));
        // Invalid code: entry c disabled with mask 10
        addVec(0, FLUSH, eo(0, 0, 0, 8'h61));
        addVec(0, tw(8'h61), eo(0, 0, 0, 8'h61));
        addVec(0, tw(8'h04), eo(0, 0, 0, 8'h61));
        addVec(0, tw(8'h62), eo(0, 0, 0, 8'h61));
        addVec(0, tw(8'h0E), eo(0, 0, 0, 8'h61));
        addVec(0, tw(8'h63), eo(0, 0, 0, 8'h61));
        addVec(0, tw(8'h0B), eo(1, 0, 0, 8'h61));
        addVec(0, bw(1), eo(1, 0, 0, 8'h61));
        addVec(0, bw(1), eo(1, 1, 0, 8'h61));
        addVec(0, bw(0), eo(1, 0, 1, 8'h61));
        addVec(0, bw(1), eo(1, 0, 0, 8'h61));
        addVec(0, bw(0), eo(1, 0, 1, 8'h62));
        // Priority: two identical codes, lowest index wins
        addVec(0, FLUSH, eo(0, 0, 0, 8'h62));
        addVec(0, tw(8'h78), eo(0, 0, 0, 8'h62));
        addVec(0, tw(8'h05), eo(0, 0, 0, 8'h62));
        addVec(0, tw(8'h79), eo(0, 0, 0, 8'h62));
        addVec(0, tw(8'h05), eo(0, 0, 0, 8'h62));
        addVec(0, tw(8'h63), eo(0, 0, 0, 8'h62));
        addVec(0, tw(8'h0F), eo(1, 0, 0, 8'h62));
        addVec(0, bw(1), eo(1, 0, 1, 8'h78));
        addVec(0, bw(0), eo(1, 0, 0, 8'h78));
        addVec(0, bw(1), eo(1, 1, 0, 8'h78));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].stim, vecs[i].expOut, $sformatf("vec%0d", i));
        end

        // Flush mid-code discards the partial accumulator
        applyStimulus(0, bw(0), eo(1, 0, 0, 8'h78), "flush-partial");
        applyStimulus(0, FLUSH, eo(0, 0, 0, 8'h78), "flush");
        applyStimulus(0, tw(8'h61), eo(0, 0, 0, 8'h78), "reload0");
        applyStimulus(0, tw(8'h04), eo(0, 0, 0, 8'h78), "reload1");
        applyStimulus(0, tw(8'h62), eo(0, 0, 0, 8'h78), "reload2");
        applyStimulus(0, tw(8'h0E), eo(0, 0, 0, 8'h78), "reload3");
        applyStimulus(0, tw(8'h63), eo(0, 0, 0, 8'h78), "reload4");
        applyStimulus(0, tw(8'h0F), eo(1, 0, 0, 8'h78), "reload5");
        applyStimulus(0, bw(0), eo(1, 0, 1, 8'h61), "flush-newdecode");

        // Reset mid-code, then bits ignored until the full table is reloaded
        applyStimulus(0, bw(1), eo(1, 0, 0, 8'h61), "rst-partial");
        applyStimulus(1, bw(0), eo(0, 0, 0, 8'h00), "rst-mid");
        applyStimulus(0, bw(1), eo(0, 0, 0, 8'h00), "rst-bit-ignored");
        applyStimulus(0, tw(8'h61), eo(0, 0, 0, 8'h00), "rst-reload0");
        applyStimulus(0, tw(8'h04), eo(0, 0, 0, 8'h00), "rst-reload1");
        applyStimulus(0, tw(8'h62), eo(0, 0, 0, 8'h00), "rst-reload2");
        applyStimulus(0, tw(8'h0E), eo(0, 0, 0, 8'h00), "rst-reload3");
        applyStimulus(0, tw(8'h63), eo(0, 0, 0, 8'h00), "rst-reload4");
        applyStimulus(0, bw(0), eo(0, 0, 0, 8'h00), "rst-bit-5words");
        applyStimulus(0, tw(8'h0F), eo(1, 0, 0, 8'h00), "rst-reload5");
        applyStimulus(0, bw(0), eo(1, 0, 1, 8'h61), "rst-decode-a");
        applyStimulus(0, bw(1), eo(1, 0, 0, 8'h61), "rst-decode-c0");
        applyStimulus(0, bw(1), eo(1, 0, 1, 8'h63), "rst-decode-c1");

        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard-leftover actual=%0d required=0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
